// File: rtl/slot_pkg.sv
// Shared types and default constants for the slot machine controller.
// Holds the reel symbol width, the FSM state type and the default pay table.
package slot_pkg;

   localparam int SYM_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      SPIN,
      STOP,
      SETTLE,
      EVAL
   } state_t;

   localparam int DEF_BET         = 1;
   localparam int DEF_PAIR_PAY    = 2;
   localparam int DEF_TRIPLE_PAY  = 10;
   localparam int DEF_JACKPOT_SYM = 7;
   localparam int DEF_JACKPOT_PAY = 50;

endpackage

// File: rtl/slot_payout_eval.sv
// Combinational scorer: settled reel symbols -> payout and jackpot flag.
// Ports: reel_val (reel k in bits [4k+3:4k]), pay, is_jackpot.
module slot_payout_eval
   import slot_pkg::*;
#(
   parameter int NUM_REELS   = 3,
   parameter int CREDIT_W    = 8,
   parameter int PAIR_PAY    = DEF_PAIR_PAY,
   parameter int TRIPLE_PAY  = DEF_TRIPLE_PAY,
   parameter int JACKPOT_SYM = DEF_JACKPOT_SYM,
   parameter int JACKPOT_PAY = DEF_JACKPOT_PAY
) (
   input  logic [SYM_W*NUM_REELS-1:0] reel_val,
   output logic [CREDIT_W-1:0]        pay,
   output logic                       is_jackpot
);

   localparam logic [SYM_W-1:0]    JP_SYM = SYM_W'(JACKPOT_SYM);
   localparam logic [CREDIT_W-1:0] PAY_P  = CREDIT_W'(PAIR_PAY);
   localparam logic [CREDIT_W-1:0] PAY_T  = CREDIT_W'(TRIPLE_PAY);
   localparam logic [CREDIT_W-1:0] PAY_J  = CREDIT_W'(JACKPOT_PAY);

   logic all_eq;
   logic any_pair;

   always_comb begin
      all_eq   = 1'b1;
      any_pair = 1'b0;
      for (int i = 1; i < NUM_REELS; i++) begin
         if (reel_val[i*SYM_W +: SYM_W] != reel_val[0 +: SYM_W])
            all_eq = 1'b0;
      end
      for (int i = 0; i < NUM_REELS - 1; i++) begin
         for (int j = i + 1; j < NUM_REELS; j++) begin
            if (reel_val[i*SYM_W +: SYM_W] == reel_val[j*SYM_W +: SYM_W])
               any_pair = 1'b1;
         end
      end
   end

   // First matching rule wins, so the order of this chain matters.
   always_comb begin
      is_jackpot = all_eq && (reel_val[0 +: SYM_W] == JP_SYM);
      if (is_jackpot)
         pay = PAY_J;
      else if (all_eq)
         pay = PAY_T;
      else if (any_pair)
         pay = PAY_P;
      else
         pay = '0;
   end

endmodule

// File: rtl/slot_spin_ctrl.sv
// Slot game controller: spins and stops reels in order, scores, keeps credits.
// Ports: clk, rst (async high), tick, start, reel_val -> running, busy,
//        credits, payout, win, jackpot (all outputs registered).
module slot_spin_ctrl
   import slot_pkg::*;
#(
   parameter int NUM_REELS     = 3,
   parameter int SPIN_MIN      = 16,
   parameter int STOP_GAP      = 8,
   parameter int CREDIT_W      = 8,
   parameter int START_CREDITS = 10,
   parameter int BET           = DEF_BET,
   parameter int PAIR_PAY      = DEF_PAIR_PAY,
   parameter int TRIPLE_PAY    = DEF_TRIPLE_PAY,
   parameter int JACKPOT_SYM   = DEF_JACKPOT_SYM,
   parameter int JACKPOT_PAY   = DEF_JACKPOT_PAY
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic                       start,
   input  logic [SYM_W*NUM_REELS-1:0] reel_val,
   output logic [NUM_REELS-1:0]       running,
   output logic                       busy,
   output logic [CREDIT_W-1:0]        credits,
   output logic [CREDIT_W-1:0]        payout,
   output logic                       win,
   output logic                       jackpot
);

   localparam int CNT_MAX = (SPIN_MIN > STOP_GAP) ? SPIN_MIN : STOP_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = $clog2(NUM_REELS + 1);

   localparam logic [CNT_W-1:0]    CNT_SPIN = CNT_W'(SPIN_MIN);
   localparam logic [CNT_W-1:0]    CNT_GAP  = CNT_W'(STOP_GAP);
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_REELS - 1);
   localparam logic [CREDIT_W-1:0] BET_C    = CREDIT_W'(BET);
   localparam logic [CREDIT_W-1:0] START_C  = CREDIT_W'(START_CREDITS);
   localparam logic [CREDIT_W-1:0] CRED_MAX = '1;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic [CREDIT_W-1:0] pay;
   logic                is_jp;
   logic [CREDIT_W:0]   sum;

   slot_payout_eval #(
      .NUM_REELS   (NUM_REELS),
      .CREDIT_W    (CREDIT_W),
      .PAIR_PAY    (PAIR_PAY),
      .TRIPLE_PAY  (TRIPLE_PAY),
      .JACKPOT_SYM (JACKPOT_SYM),
      .JACKPOT_PAY (JACKPOT_PAY)
   ) u_eval (
      .reel_val   (reel_val),
      .pay        (pay),
      .is_jackpot (is_jp)
   );

   // One spare bit catches the carry so the balance clips instead of wrapping.
   assign sum = {1'b0, credits} + {1'b0, pay};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         running <= '0;
         busy    <= 1'b0;
         credits <= START_C;
         payout  <= '0;
         win     <= 1'b0;
         jackpot <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && credits >= BET_C) begin
                  credits <= credits - BET_C;
                  running <= '1;
                  busy    <= 1'b1;
                  payout  <= '0;
                  win     <= 1'b0;
                  jackpot <= 1'b0;
                  cnt     <= CNT_SPIN;
                  state   <= SPIN;
               end
            end
            SPIN: begin
               if (tick) begin
                  if (cnt == CNT_ONE) begin
                     running[0] <= 1'b0;
                     idx        <= IDX_ONE;
                     cnt        <= CNT_GAP;
                     state      <= STOP;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (cnt == CNT_ONE) begin
                     for (int k = 1; k < NUM_REELS; k++) begin
                        if (idx == IDX_W'(k))
                           running[k] <= 1'b0;
                     end
                     idx <= idx + IDX_ONE;
                     if (idx == IDX_LAST)
                        state <= SETTLE;
                     else
                        cnt <= CNT_GAP;
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
            end
            // Last reel gets one full tick to land before it is sampled.
            SETTLE: begin
               if (tick)
                  state <= EVAL;
            end
            EVAL: begin
               payout  <= pay;
               win     <= (pay != '0);
               jackpot <= is_jp;
               credits <= sum[CREDIT_W] ? CRED_MAX : sum[CREDIT_W-1:0];
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
